// File: rtl/wdg_rst_gen_if.sv
// Stage-output bus between the watchdog/software side and wdg_rst_gen.
// master: drives the timeout levels and software pulses.
// slave : the reset generator, which returns the interrupt/reset status.
interface wdg_rst_gen_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 irq1;
  logic                 irq2;
  logic                 irq_ack;
  logic                 cause_clr;
  logic                 irq_pend;
  logic                 rst_pending;
  logic                 sys_rst_n;
  logic                 rst_cause_wdg;
  logic [CNT_WIDTH-1:0] rst_count;

  modport master (
    output irq1, irq2, irq_ack, cause_clr,
    input  irq_pend, rst_pending, sys_rst_n, rst_cause_wdg, rst_count
  );

  modport slave (
    input  irq1, irq2, irq_ack, cause_clr,
    output irq_pend, rst_pending, sys_rst_n, rst_cause_wdg, rst_count
  );
endinterface

// File: rtl/wdg_rst_gen.sv
// Watchdog reset generator: stage-1 timeout -> pending interrupt with ack,
// stage-2 timeout -> holdoff / stretched sys_rst_n pulse / recovery.
// Runs in the power-on reset domain (res_n), never from sys_rst_n.
// Optional macro WDG_RSTGEN_CAUSE_EN adds the sticky watchdog-cause flag
// and the saturating watchdog-reset counter; without it both read 0.
module wdg_rst_gen #(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int PULSE_CYCLES   = 64,
  parameter int RECOVER_CYCLES = 32,
  parameter int CNT_WIDTH      = 8
) (
  input logic          clk,
  input logic          res_n,
  wdg_rst_gen_if.slave bus
);

  localparam int MAX_HP = (HOLDOFF_CYCLES > PULSE_CYCLES) ? HOLDOFF_CYCLES : PULSE_CYCLES;
  localparam int MAX_C  = (MAX_HP > RECOVER_CYCLES) ? MAX_HP : RECOVER_CYCLES;
  localparam int TW     = $clog2(MAX_C) + 1;

  // Reload values; zero-length phases are skipped by the FSM, so their load is unused.
  localparam logic [TW-1:0] HOLD_LD  = (HOLDOFF_CYCLES > 0) ? TW'(HOLDOFF_CYCLES - 1) : '0;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] REC_LD   = (RECOVER_CYCLES > 0) ? TW'(RECOVER_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_ASSERT,
    ST_RECOVER
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          rst_pending_q;
  logic          sys_rst_n_q;
  logic          irq1_q;
  logic          irq_pend_q;

  // Stage-1: edge-detect irq1 into a pending flag; a new edge beats a same-cycle ack.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      irq1_q     <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq1_q <= bus.irq1;
      if (bus.irq1 && !irq1_q) begin
        irq_pend_q <= 1'b1;
      end else if (bus.irq_ack) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  // Stage-2 sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      rst_pending_q <= 1'b0;
      sys_rst_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.irq2) begin
            if (HOLDOFF_CYCLES > 0) begin
              state_q       <= ST_HOLDOFF;
              timer_q       <= HOLD_LD;
              rst_pending_q <= 1'b1;
            end else begin
              state_q     <= ST_ASSERT;
              timer_q     <= PULSE_LD;
              sys_rst_n_q <= 1'b0;
            end
          end
        end
        ST_HOLDOFF: begin
          if (timer_q == '0) begin
            state_q       <= ST_ASSERT;
            timer_q       <= PULSE_LD;
            rst_pending_q <= 1'b0;
            sys_rst_n_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_ASSERT: begin
          if (timer_q == '0) begin
            sys_rst_n_q <= 1'b1;
            if (RECOVER_CYCLES > 0) begin
              state_q <= ST_RECOVER;
              timer_q <= REC_LD;
            end else begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_RECOVER: begin
          if (timer_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          timer_q       <= '0;
          rst_pending_q <= 1'b0;
          sys_rst_n_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.irq_pend    = irq_pend_q;
  assign bus.rst_pending = rst_pending_q;
  assign bus.sys_rst_n   = sys_rst_n_q;

`ifdef WDG_RSTGEN_CAUSE_EN
  logic                 assert_entry;
  logic                 cause_q;
  logic                 cause_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Detect the cycle the sequencer moves into ASSERT.
  always_comb begin
    assert_entry = 1'b0;
    if (state_q == ST_IDLE && bus.irq2 && HOLDOFF_CYCLES == 0) begin
      assert_entry = 1'b1;
    end
    if (state_q == ST_HOLDOFF && timer_q == '0) begin
      assert_entry = 1'b1;
    end
  end

  // Clear is applied first so a coincident ASSERT entry leaves count=1, flag=1.
  always_comb begin
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (bus.cause_clr) begin
      cnt_d   = '0;
      cause_d = 1'b0;
    end
    if (assert_entry) begin
      cause_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_WIDTH'(1);
      end
    end
  end

  // Cause record: only res_n clears it, never the sys_rst_n it produced.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cause_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rst_cause_wdg = cause_q;
  assign bus.rst_count     = cnt_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr  = bus.cause_clr;
  assign bus.rst_cause_wdg = 1'b0;
  assign bus.rst_count     = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_wdg_rst_gen.sv
// Bench for wdg_rst_gen: a default-parameter instance and a minimal-timing
// instance (holdoff 0, pulse 1, recover 0, 2-bit counter) share the stimulus.
// Expected values come from a timeline model: each sequence is a start cycle,
// and every output follows from the distance to that start.
module tb_wdg_rst_gen;

  localparam int HA = 16, PA = 64, RA = 32, CWA = 8;
  localparam int HB = 0,  PB = 1,  RB = 0,  CWB = 2;
`ifdef WDG_RSTGEN_CAUSE_EN
  localparam bit CAUSE = 1'b1;
`else
  localparam bit CAUSE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  logic irq1  = 1'b0;
  logic irq2  = 1'b0;
  logic ack   = 1'b0;
  logic clr   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  wdg_rst_gen_if #(.CNT_WIDTH(CWA)) ifa ();
  wdg_rst_gen_if #(.CNT_WIDTH(CWB)) ifb ();

  assign ifa.irq1 = irq1;  assign ifa.irq2 = irq2;
  assign ifa.irq_ack = ack; assign ifa.cause_clr = clr;
  assign ifb.irq1 = irq1;  assign ifb.irq2 = irq2;
  assign ifb.irq_ack = ack; assign ifb.cause_clr = clr;

  wdg_rst_gen #(
    .HOLDOFF_CYCLES(HA), .PULSE_CYCLES(PA), .RECOVER_CYCLES(RA), .CNT_WIDTH(CWA)
  ) dut_a (
    .clk(clk), .res_n(res_n), .bus(ifa)
  );

  wdg_rst_gen #(
    .HOLDOFF_CYCLES(HB), .PULSE_CYCLES(PB), .RECOVER_CYCLES(RB), .CNT_WIDTH(CWB)
  ) dut_b (
    .clk(clk), .res_n(res_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_h[2]    = '{HA, HB};
  int m_p[2]    = '{PA, PB};
  int m_r[2]    = '{RA, RB};
  int m_cmax[2] = '{(1 << CWA) - 1, (1 << CWB) - 1};
  bit m_act[2];
  int m_start[2];
  bit m_pend[2];
  bit m_prev1[2];
  bit m_cause[2];
  int m_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_start[i] = 0; m_pend[i] = 1'b0;
      m_prev1[i] = 1'b0; m_cause[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // Apply the inputs presented at this clock edge.
  task automatic model_edge();
    int tot;
    bit busy;
    int base;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      tot  = m_h[i] + m_p[i] + m_r[i];
      busy = m_act[i] && ((cyc - 1 - m_start[i]) < tot);
      if (irq1 && !m_prev1[i]) m_pend[i] = 1'b1;
      else if (ack)            m_pend[i] = 1'b0;
      m_prev1[i] = irq1;
      if (!busy && irq2) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc;
      end
      if (m_act[i] && (cyc - m_start[i]) == m_h[i]) begin
        base       = clr ? 0 : m_cnt[i];
        m_cnt[i]   = (base + 1 > m_cmax[i]) ? m_cmax[i] : base + 1;
        m_cause[i] = 1'b1;
      end else if (clr) begin
        m_cnt[i]   = 0;
        m_cause[i] = 1'b0;
      end
    end
  endtask

  task automatic model_expect(input int i, output bit pend, output bit rp,
                              output bit srn, output bit cw, output int cnt);
    int d;
    bit on;
    d    = cyc - m_start[i];
    on   = m_act[i] && (d < m_h[i] + m_p[i] + m_r[i]);
    pend = m_pend[i];
    rp   = on && (d < m_h[i]);
    srn  = !(on && d >= m_h[i] && d < m_h[i] + m_p[i]);
    cw   = m_cause[i] & CAUSE;
    cnt  = CAUSE ? m_cnt[i] : 0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    bit p, rp, sn, cw;
    int cn;
    model_expect(0, p, rp, sn, cw, cn);
    check_eq("A.irq_pend",      32'(ifa.irq_pend),      32'(p));
    check_eq("A.rst_pending",   32'(ifa.rst_pending),   32'(rp));
    check_eq("A.sys_rst_n",     32'(ifa.sys_rst_n),     32'(sn));
    check_eq("A.rst_cause_wdg", 32'(ifa.rst_cause_wdg), 32'(cw));
    check_eq("A.rst_count",     32'(ifa.rst_count),     32'(cn));
    model_expect(1, p, rp, sn, cw, cn);
    check_eq("B.irq_pend",      32'(ifb.irq_pend),      32'(p));
    check_eq("B.rst_pending",   32'(ifb.rst_pending),   32'(rp));
    check_eq("B.sys_rst_n",     32'(ifb.sys_rst_n),     32'(sn));
    check_eq("B.rst_cause_wdg", 32'(ifb.rst_cause_wdg), 32'(cw));
    check_eq("B.rst_count",     32'(ifb.rst_count),     32'(cn));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Drop res_n mid-cycle, check outputs before any clock edge, then release.
  task automatic async_reset();
    #3;
    res_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst.sys_rst_n_async", 32'(ifa.sys_rst_n), 32'd1);
    @(posedge clk);
    #2;
    res_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    int late_pend;
    model_reset();
    #12;
    check_all();
    #5;
    res_n = 1'b1;

    // Single-cycle irq2 at edge 10.
    repeat (9) tick();
    irq2 = 1'b1;
    tick();
    check_eq("t1.pend_first", 32'(ifa.rst_pending), 32'd1);
    irq2 = 1'b0;
    lows = 0;
    for (int e = 11; e <= 130; e++) begin
      tick();
      if (ifa.sys_rst_n === 1'b0) lows++;
      if (e == 25) check_eq("t1.pend_last", 32'(ifa.rst_pending), 32'd1);
      if (e == 26) check_eq("t1.pend_off",  32'(ifa.rst_pending), 32'd0);
      if (e == 26) check_eq("t1.rst_first", 32'(ifa.sys_rst_n),   32'd0);
      if (e == 89) check_eq("t1.rst_last",  32'(ifa.sys_rst_n),   32'd0);
      if (e == 90) check_eq("t1.rst_rel",   32'(ifa.sys_rst_n),   32'd1);
    end
    check_eq("t1.pulse_width", 32'(lows), 32'd64);

    // Cause record after one sequence, then cleared.
    check_eq("t6.cause_set", 32'(ifa.rst_cause_wdg), 32'(CAUSE));
    check_eq("t6.count_one", 32'(ifa.rst_count),     32'(CAUSE));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t6.cause_clr", 32'(ifa.rst_cause_wdg), 32'd0);
    check_eq("t6.count_clr", 32'(ifa.rst_count),     32'd0);

    // irq1 edge, ack, held level, edge coincident with ack.
    irq1 = 1'b1;
    tick();
    check_eq("t2.pend_set", 32'(ifa.irq_pend), 32'd1);
    repeat (4) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("t2.pend_ack", 32'(ifa.irq_pend), 32'd0);
    repeat (5) tick();
    check_eq("t2.pend_level", 32'(ifa.irq_pend), 32'd0);
    irq1 = 1'b0;
    tick();
    irq1 = 1'b1;
    ack  = 1'b1;
    tick();
    ack  = 1'b0;
    check_eq("t2.pend_set_wins", 32'(ifa.irq_pend), 32'd1);
    irq1 = 1'b0;
    tick();

    // irq2 held: B toggles and saturates, A retriggers after recovery.
    irq2 = 1'b1;
    lows = 0;
    for (int t = 1; t <= 130; t++) begin
      tick();
      if (ifb.sys_rst_n === 1'b0) lows++;
    end
    irq2 = 1'b0;
    check_eq("t3.b_lows", 32'(lows), 32'd65);
    check_eq("t3.b_count_sat", 32'(ifb.rst_count), CAUSE ? 32'd3 : 32'd0);
    repeat (120) tick();

    // irq2 pulse during RECOVER is ignored.
    irq2 = 1'b1;
    tick();
    irq2 = 1'b0;
    lows = 0;
    late_pend = 0;
    for (int d = 1; d <= 125; d++) begin
      irq2 = (d == 86);
      tick();
      if (ifa.sys_rst_n === 1'b0) lows++;
      if (d >= 112 && ifa.rst_pending !== 1'b0) late_pend++;
    end
    irq2 = 1'b0;
    check_eq("t4.recover_pulse_width", 32'(lows), 32'd64);
    check_eq("t4.no_retrigger", 32'(late_pend), 32'd0);

    // irq2 dropped during HOLDOFF still yields a full pulse.
    irq2 = 1'b1;
    repeat (5) tick();
    irq2 = 1'b0;
    lows = 0;
    for (int d = 5; d <= 120; d++) begin
      tick();
      if (ifa.sys_rst_n === 1'b0) lows++;
    end
    check_eq("t4.abort_ignored_width", 32'(lows), 32'd64);

    // res_n during the 20th ASSERT cycle, then a full sequence.
    irq2 = 1'b1;
    tick();
    irq2 = 1'b0;
    repeat (HA + 19) tick();
    check_eq("t5.in_assert", 32'(ifa.sys_rst_n), 32'd0);
    async_reset();
    repeat (3) tick();
    irq2 = 1'b1;
    tick();
    irq2 = 1'b0;
    lows = 0;
    for (int d = 1; d <= 120; d++) begin
      tick();
      if (ifa.sys_rst_n === 1'b0) lows++;
    end
    check_eq("t5.full_after_reset", 32'(lows), 32'd64);

    // cause_clr on the ASSERT-entry cycle: increment wins.
    irq2 = 1'b1;
    tick();
    irq2 = 1'b0;
    repeat (HA - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t6.clr_entry_flag",  32'(ifa.rst_cause_wdg), 32'(CAUSE));
    check_eq("t6.clr_entry_count", 32'(ifa.rst_count),     32'(CAUSE));
    repeat (110) tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      irq1 = ($urandom_range(0, 3) == 0) ? ~irq1 : irq1;
      irq2 = ($urandom_range(0, 29) == 0);
      ack  = ($urandom_range(0, 7) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
